// File: rtl/trip_timer.sv
// rtl/trip_timer.sv - taxi meter elapsed-time counter (h:m:s) with run/pause FSM
// Prescaler turns clk into 1 s steps; cascade s->m->h with wrap or saturate on overflow.
module trip_timer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HR_MAX   = 24,
  parameter int SATURATE = 0
) (
  input  logic       clk,
  input  logic       sys_reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       clr,
  output logic [5:0] data_s,
  output logic [5:0] data_m,
  output logic [4:0] data_h,
  output logic       tick_1s,
  output logic       tick_1m,
  output logic       running,
  output logic       ovf
);

  localparam int              PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   P_LAST = PW'(CLK_HZ - 1);
  localparam logic [5:0]      S_LAST = 6'(SEC_MAX - 1);
  localparam logic [5:0]      M_LAST = 6'(MIN_MAX - 1);
  localparam logic [4:0]      H_LAST = 5'(HR_MAX - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic          tick_1s_q, tick_1s_d, tick_1m_q, tick_1m_d;
  logic          running_q, running_d, ovf_q, ovf_d;
  logic          frozen, advance, sec_tick;

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (hold)  state_d = PAUSE;
        PAUSE:   if (!hold) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // A saturated counter stays pinned at max until clr, so nothing advances.
  always_comb begin
    frozen    = (SATURATE != 0) && ovf_q;
    advance   = (state_q == RUN) && !stop && !clr && !frozen;
    sec_tick  = advance && (pre_q == P_LAST);
    running_d = (state_d == RUN);
    pre_d     = pre_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    ovf_d     = ovf_q;
    tick_1s_d = 1'b0;
    tick_1m_d = 1'b0;
    if (clr) begin
      pre_d = '0;
      sec_d = '0;
      min_d = '0;
      hr_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (state_d == IDLE) begin
        pre_d = '0;
      end else if (advance) begin
        pre_d = sec_tick ? '0 : pre_q + PW'(1);
      end
      if (sec_tick) begin
        if (sec_q != S_LAST) begin
          sec_d     = sec_q + 6'd1;
          tick_1s_d = 1'b1;
        end else if (min_q != M_LAST) begin
          sec_d     = '0;
          min_d     = min_q + 6'd1;
          tick_1s_d = 1'b1;
          tick_1m_d = 1'b1;
        end else if (hr_q != H_LAST) begin
          sec_d     = '0;
          min_d     = '0;
          hr_d      = hr_q + 5'd1;
          tick_1s_d = 1'b1;
          tick_1m_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
          if (SATURATE == 0) begin
            sec_d     = '0;
            min_d     = '0;
            hr_d      = '0;
            tick_1s_d = 1'b1;
            tick_1m_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      tick_1s_q <= 1'b0;
      tick_1m_q <= 1'b0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      tick_1s_q <= tick_1s_d;
      tick_1m_q <= tick_1m_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  assign data_s  = sec_q;
  assign data_m  = min_q;
  assign data_h  = hr_q;
  assign tick_1s = tick_1s_q;
  assign tick_1m = tick_1m_q;
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule
